// File: rtl/memory_game_ctrl_pkg.sv
// Shared types and constants for the 4x4 memory-card game controller.
package memgame_pkg;

    localparam int GRID    = 4;
    localparam int N_CARDS = 16;
    localparam int N_PAIRS = 8;

    typedef enum logic [2:0] {
        PICK1,
        PICK2,
        CMP,
        HOLD,
        DONE
    } state_t;

    // Linear card index: row*4 + col.
    function automatic logic [3:0] card_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/memory_game_ctrl_hold_timer.sv
// Loadable down-counter that sits at zero once expired; times the mismatch display.
module hold_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [25:0] load_val,
    output logic        zero
);

    logic [25:0] cnt_q;
    logic [25:0] cnt_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 26'd0) begin
            cnt_d = cnt_q - 26'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 26'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 26'd0);

endmodule

// File: rtl/memory_game_ctrl.sv
// Memory-card game sequencer: cursor, pick/compare/hold FSM, matched mask and score.
module memory_game_ctrl
    import memgame_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int SYM_W       = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic                   btn_sel,
    input  logic [16*SYM_W-1:0]    card_sym,
    output logic [15:0]            open_cards,
    output logic [1:0]             cur_x,
    output logic [1:0]             cur_y,
    output logic [3:0]             pairs_found,
    output logic [7:0]             attempts,
    output logic                   busy,
    output logic                   game_over
);

    localparam logic [25:0] HOLD_LOAD = 26'(HOLD_CYCLES - 1);

    state_t               state_q, state_d;
    logic [1:0]           cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [N_CARDS-1:0]   matched_q, matched_d, pend_q, pend_d;
    logic [N_CARDS-1:0]   open_q, open_d;
    logic [3:0]           idx1_q, idx1_d, idx2_q, idx2_d;
    logic [3:0]           pairs_q, pairs_d;
    logic [7:0]           attempts_q, attempts_d;
    logic                 busy_q, busy_d, over_q, over_d;
    logic                 tmr_load_s, tmr_zero_s;
    logic [3:0]           sel_idx_s;
    logic                 face_up_s;
    logic [SYM_W-1:0]     sym1_s, sym2_s;

    hold_timer u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load_s),
        .load_val (HOLD_LOAD),
        .zero     (tmr_zero_s)
    );

    assign sel_idx_s = card_idx(cur_y_q, cur_x_q);
    assign face_up_s = matched_q[sel_idx_s] | pend_q[sel_idx_s];
    assign sym1_s    = card_sym[idx1_q*SYM_W +: SYM_W];
    assign sym2_s    = card_sym[idx2_q*SYM_W +: SYM_W];

    // Next-state, cursor, pick bookkeeping and the registered output image.
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        matched_d  = matched_q;
        pend_d     = pend_q;
        idx1_d     = idx1_q;
        idx2_d     = idx2_q;
        pairs_d    = pairs_q;
        attempts_d = attempts_q;
        tmr_load_s = 1'b0;

        // Select always swallows a simultaneous move; one move per cycle.
        if (state_q != DONE && !btn_sel) begin
            if (btn_up) begin
                cur_y_d = cur_y_q - 2'd1;
            end else if (btn_down) begin
                cur_y_d = cur_y_q + 2'd1;
            end else if (btn_left) begin
                cur_x_d = cur_x_q - 2'd1;
            end else if (btn_right) begin
                cur_x_d = cur_x_q + 2'd1;
            end else begin
                cur_x_d = cur_x_q;
            end
        end else begin
            cur_x_d = cur_x_q;
        end

        case (state_q)
            PICK1: begin
                if (btn_sel && !face_up_s) begin
                    pend_d[sel_idx_s] = 1'b1;
                    idx1_d            = sel_idx_s;
                    state_d           = PICK2;
                end else begin
                    state_d = PICK1;
                end
            end
            PICK2: begin
                if (btn_sel && !face_up_s) begin
                    pend_d[sel_idx_s] = 1'b1;
                    idx2_d            = sel_idx_s;
                    if (attempts_q != 8'hFF) begin
                        attempts_d = attempts_q + 8'd1;
                    end else begin
                        attempts_d = attempts_q;
                    end
                    state_d = CMP;
                end else begin
                    state_d = PICK2;
                end
            end
            CMP: begin
                if (sym1_s == sym2_s) begin
                    matched_d = matched_q | pend_q;
                    pend_d    = 16'h0000;
                    pairs_d   = pairs_q + 4'd1;
                    state_d   = (pairs_q == 4'(N_PAIRS - 1)) ? DONE : PICK1;
                end else begin
                    tmr_load_s = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (tmr_zero_s) begin
                    pend_d  = 16'h0000;
                    state_d = PICK1;
                end else begin
                    state_d = HOLD;
                end
            end
            DONE: begin
                if (btn_sel) begin
                    matched_d  = 16'h0000;
                    pend_d     = 16'h0000;
                    pairs_d    = 4'd0;
                    attempts_d = 8'd0;
                    cur_x_d    = 2'd0;
                    cur_y_d    = 2'd0;
                    state_d    = PICK1;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = PICK1;
            end
        endcase

        open_d = (state_d == DONE) ? 16'hFFFF : (matched_d | pend_d);
        busy_d = (state_d == CMP) || (state_d == HOLD);
        over_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PICK1;
            cur_x_q    <= 2'd0;
            cur_y_q    <= 2'd0;
            matched_q  <= 16'h0000;
            pend_q     <= 16'h0000;
            open_q     <= 16'h0000;
            idx1_q     <= 4'd0;
            idx2_q     <= 4'd0;
            pairs_q    <= 4'd0;
            attempts_q <= 8'd0;
            busy_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            matched_q  <= matched_d;
            pend_q     <= pend_d;
            open_q     <= open_d;
            idx1_q     <= idx1_d;
            idx2_q     <= idx2_d;
            pairs_q    <= pairs_d;
            attempts_q <= attempts_d;
            busy_q     <= busy_d;
            over_q     <= over_d;
        end
    end

    assign open_cards  = open_q;
    assign cur_x       = cur_x_q;
    assign cur_y       = cur_y_q;
    assign pairs_found = pairs_q;
    assign attempts    = attempts_q;
    assign busy        = busy_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl: directed scenarios plus random button traffic vs a game model.
module tb_memory_game_ctrl;

    localparam int HOLD  = 4;
    localparam int SYM_W = 3;

    localparam int PH_PICK1 = 0;
    localparam int PH_PICK2 = 1;
    localparam int PH_CMP   = 2;
    localparam int PH_HOLD  = 3;
    localparam int PH_DONE  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [47:0] card_sym;
    logic [15:0] open_cards;
    logic [1:0]  cur_x, cur_y;
    logic [3:0]  pairs_found;
    logic [7:0]  attempts;
    logic        busy, game_over;

    memory_game_ctrl #(.HOLD_CYCLES(HOLD), .SYM_W(SYM_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_sel     (btn_sel),
        .card_sym    (card_sym),
        .open_cards  (open_cards),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .pairs_found (pairs_found),
        .attempts    (attempts),
        .busy        (busy),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_x, m_y, m_phase, m_first, m_second, m_pairs, m_attempts, m_hold_left;
    bit m_matched[16];

    function automatic int sym(input int k);
        logic [47:0] v;
        v = card_sym;
        return int'(v[k*SYM_W +: SYM_W]);
    endfunction

    function automatic logic [15:0] m_open();
        logic [15:0] v;
        if (m_phase == PH_DONE) return 16'hFFFF;
        v = 16'h0000;
        for (int k = 0; k < 16; k++) v[k] = m_matched[k];
        if (m_phase == PH_PICK2 || m_phase == PH_CMP || m_phase == PH_HOLD) v[m_first] = 1'b1;
        if (m_phase == PH_CMP || m_phase == PH_HOLD) v[m_second] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_phase = PH_PICK1; m_first = 0; m_second = 0;
        m_pairs = 0; m_attempts = 0; m_hold_left = 0;
        for (int k = 0; k < 16; k++) m_matched[k] = 1'b0;
    endtask

    task automatic model_step(input bit u, input bit d, input bit l, input bit r, input bit s);
        int idx;
        int old_phase;
        logic [15:0] op;
        idx = m_y * 4 + m_x;
        op = m_open();
        old_phase = m_phase;
        case (m_phase)
            PH_PICK1: if (s && !op[idx]) begin m_first = idx; m_phase = PH_PICK2; end
            PH_PICK2: if (s && !op[idx]) begin
                m_second = idx;
                if (m_attempts < 255) m_attempts++;
                m_phase = PH_CMP;
            end
            PH_CMP: begin
                if (sym(m_first) == sym(m_second)) begin
                    m_matched[m_first] = 1'b1;
                    m_matched[m_second] = 1'b1;
                    m_pairs++;
                    m_phase = (m_pairs == 8) ? PH_DONE : PH_PICK1;
                end else begin
                    m_hold_left = HOLD;
                    m_phase = PH_HOLD;
                end
            end
            PH_HOLD: begin
                m_hold_left--;
                if (m_hold_left == 0) m_phase = PH_PICK1;
            end
            PH_DONE: if (s) begin
                for (int k = 0; k < 16; k++) m_matched[k] = 1'b0;
                m_pairs = 0; m_attempts = 0; m_x = 0; m_y = 0; m_phase = PH_PICK1;
            end
            default: m_phase = PH_PICK1;
        endcase
        if (old_phase != PH_DONE && !s) begin
            if (u)      m_y = (m_y + 3) % 4;
            else if (d) m_y = (m_y + 1) % 4;
            else if (l) m_x = (m_x + 3) % 4;
            else if (r) m_x = (m_x + 1) % 4;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".open"},  32'(open_cards),  32'(m_open()));
        check({tag, ".cur_x"}, 32'(cur_x),       32'(m_x));
        check({tag, ".cur_y"}, 32'(cur_y),       32'(m_y));
        check({tag, ".pairs"}, 32'(pairs_found), 32'(m_pairs));
        check({tag, ".att"},   32'(attempts),    32'(m_attempts));
        check({tag, ".busy"},  32'(busy),        32'(m_phase == PH_CMP || m_phase == PH_HOLD));
        check({tag, ".over"},  32'(game_over),   32'(m_phase == PH_DONE));
    endtask

    // One clock with the given button pulses, then compare against the model.
    task automatic cycle(input string tag, input bit u, input bit d, input bit l, input bit r, input bit s);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_sel = s;
        @(posedge clk);
        model_step(u, d, l, r, s);
        #1;
        check_outputs(tag);
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_sel = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic goto_card(input int idx);
        while (m_x != idx % 4) cycle("nav", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        while (m_y != idx / 4) cycle("nav", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_sorted_layout();
        for (int k = 0; k < 16; k++) card_sym[k*SYM_W +: SYM_W] = 3'(k >> 1);
    endtask

    initial begin
        int perm[16];
        set_sorted_layout();
        do_reset("reset");

        // Cursor wrap: 3x left, 2x up from (0,0).
        for (int i = 0; i < 3; i++) cycle("left", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle("up", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap.cur_x", 32'(cur_x), 32'd1);
        check("wrap.cur_y", 32'(cur_y), 32'd2);
        check("wrap.open", 32'(open_cards), 32'd0);

        // Matching pair 0/1.
        do_reset("reset2");
        cycle("m.sel1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("m.right", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("m.sel2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("m.cmp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("match.open", 32'(open_cards), 32'h0003);
        check("match.pairs", 32'(pairs_found), 32'd1);
        check("match.att", 32'(attempts), 32'd1);
        check("match.busy", 32'(busy), 32'd0);

        // Mismatch 0/2 with sel and moves during HOLD.
        do_reset("reset3");
        cycle("h.sel1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("h.r", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("h.r", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("h.sel2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("hold.open0", 32'(open_cards), 32'h0005);
        cycle("h.seldn", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("hold.open1", 32'(open_cards), 32'h0005);
        cycle("h.dn", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold.open2", 32'(open_cards), 32'h0005);
        cycle("h.sel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("hold.open3", 32'(open_cards), 32'h0005);
        cycle("h.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold.open4", 32'(open_cards), 32'h0005);
        cycle("h.end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold.closed", 32'(open_cards), 32'h0000);
        check("hold.cur_y", 32'(cur_y), 32'd1);
        check("hold.cur_x", 32'(cur_x), 32'd2);

        // Re-selecting an open card is ignored.
        do_reset("reset4");
        cycle("s.sel1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("s.same", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("same.att", 32'(attempts), 32'd0);
        check("same.open", 32'(open_cards), 32'h0001);
        cycle("s.r", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("s.sel2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("s.cmp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("s.l", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle("s.matched", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("matched.open", 32'(open_cards), 32'h0003);
        check("matched.att", 32'(attempts), 32'd1);
        check("matched.busy", 32'(busy), 32'd0);

        // Full game, then restart.
        do_reset("reset5");
        for (int p = 0; p < 8; p++) begin
            goto_card(2 * p);
            cycle("g.sel1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            goto_card(2 * p + 1);
            cycle("g.sel2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cycle("g.cmp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("done.over", 32'(game_over), 32'd1);
        check("done.open", 32'(open_cards), 32'hFFFF);
        check("done.pairs", 32'(pairs_found), 32'd8);
        check("done.att", 32'(attempts), 32'd8);
        cycle("d.move", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("d.restart", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("restart.over", 32'(game_over), 32'd0);
        check("restart.open", 32'(open_cards), 32'd0);
        check("restart.pairs", 32'(pairs_found), 32'd0);
        check("restart.att", 32'(attempts), 32'd0);
        check("restart.cur", 32'({cur_y, cur_x}), 32'd0);

        // Reset mid-HOLD, then simultaneous up+left.
        do_reset("reset6");
        cycle("r.sel1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("r.r", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("r.r", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("r.sel2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("r.cmp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("r.hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midhold.busy", 32'(busy), 32'd1);
        do_reset("midhold_rst");
        check("midhold.open", 32'(open_cards), 32'd0);
        check("midhold.x", 32'(cur_x), 32'd0);
        cycle("upleft", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("upleft.y", 32'(cur_y), 32'd3);
        check("upleft.x", 32'(cur_x), 32'd0);

        // Random traffic: shuffled legal layout, then an arbitrary layout.
        for (int run = 0; run < 2; run++) begin
            for (int k = 0; k < 16; k++) perm[k] = k >> 1;
            for (int k = 15; k > 0; k--) begin
                int j, t;
                j = int'($urandom_range(k, 0));
                t = perm[k]; perm[k] = perm[j]; perm[j] = t;
            end
            for (int k = 0; k < 16; k++)
                card_sym[k*SYM_W +: SYM_W] = (run == 0) ? 3'(perm[k]) : 3'($urandom_range(7, 0));
            do_reset("rnd_reset");
            for (int c = 0; c < 1500; c++) begin
                cycle("rnd",
                      ($urandom_range(5, 0) == 0), ($urandom_range(5, 0) == 0),
                      ($urandom_range(5, 0) == 0), ($urandom_range(5, 0) == 0),
                      ($urandom_range(3, 0) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
